// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and state helpers for the stopwatch run/stop/lap controller.
// Latency: none, declarations only; backpressure: none.
package stopwatch_ctrl_pkg;

  localparam int DIGITS_W = 20;

  typedef logic [DIGITS_W-1:0] digits_t;

  typedef enum logic [2:0] {
    ST_LOCKWAIT = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_IDLE     = 3'd2,
    ST_RUN      = 3'd3,
    ST_LAP_RUN  = 3'd4,
    ST_LAP_STOP = 3'd5,
    ST_STOP     = 3'd6
  } sw_state_e;

  function automatic logic is_running(sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP_RUN);
  endfunction

  function automatic logic is_lap(sw_state_e s);
    return (s == ST_LAP_RUN) || (s == ST_LAP_STOP);
  endfunction

  function automatic logic is_clearing(sw_state_e s);
    return (s == ST_LOCKWAIT) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Controller-facing signal bundle: buttons, lock, counter digits in; enables, clear, display out.
// Latency: none, wiring only; backpressure: none.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic    dcm_lock;
  logic    strtstop;
  logic    lap;
  digits_t cnt_in;
  logic    cnt_ce;
  logic    cnt_clr;
  digits_t disp_out;
  logic    run_led;
  logic    lap_active;

  modport master (
    output dcm_lock, strtstop, lap, cnt_in,
    input  cnt_ce, cnt_clr, disp_out, run_led, lap_active
  );

  modport slave (
    input  dcm_lock, strtstop, lap, cnt_in,
    output cnt_ce, cnt_clr, disp_out, run_led, lap_active
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge press detector for a debounced level button; history resets high so a held button is no press.
// Latency: press is combinational in the cycle the level rises; backpressure: none.
module stopwatch_ctrl_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= btn;
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap sequencer: 10 ms count enable, counter-chain clear sequencing, lap snapshot display mux.
// Latency: state and outputs registered one cycle after a press; backpressure: none.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 262144,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  sw
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  sw_state_e        state, state_nxt;
  logic [PRE_W-1:0] presc;
  logic [CLR_W-1:0] clr_cnt;
  digits_t          lap_reg;
  logic             cnt_ce_r, cnt_clr_r, run_led_r, lap_active_r;
  logic             ss_raw, lap_raw, ss_press, lap_press;

  stopwatch_ctrl_btn_edge u_ss_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (sw.strtstop),
    .press (ss_raw)
  );

  stopwatch_ctrl_btn_edge u_lap_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (sw.lap),
    .press (lap_raw)
  );

  // Start/stop wins a same-cycle tie; the lap press is dropped.
  assign ss_press  = ss_raw;
  assign lap_press = lap_raw & ~ss_raw;

  always_comb begin
    state_nxt = state;
    if (!sw.dcm_lock) begin
      state_nxt = ST_LOCKWAIT;
    end else begin
      case (state)
        ST_LOCKWAIT: state_nxt = ST_CLEAR;
        ST_CLEAR:    if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
        ST_IDLE:     if (ss_press) state_nxt = ST_RUN;
        ST_RUN: begin
          if (ss_press)       state_nxt = ST_STOP;
          else if (lap_press) state_nxt = ST_LAP_RUN;
        end
        ST_LAP_RUN: begin
          if (ss_press)       state_nxt = ST_LAP_STOP;
          else if (lap_press) state_nxt = ST_RUN;
        end
        ST_LAP_STOP: begin
          if (ss_press)       state_nxt = ST_LAP_RUN;
          else if (lap_press) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (ss_press)       state_nxt = ST_RUN;
          else if (lap_press) state_nxt = ST_CLEAR;
        end
        default: state_nxt = ST_LOCKWAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOCKWAIT;
      clr_cnt      <= '0;
      presc        <= '0;
      lap_reg      <= '0;
      cnt_ce_r     <= 1'b0;
      cnt_clr_r    <= 1'b1;
      run_led_r    <= 1'b0;
      lap_active_r <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_cnt      <= (state == ST_CLEAR && state_nxt == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      cnt_clr_r    <= is_clearing(state_nxt);
      run_led_r    <= is_running(state_nxt);
      lap_active_r <= is_lap(state_nxt);

      // A tick due on the edge that leaves a running state is held pending
      // at PRE_MAX and fires on the first running edge after resume.
      cnt_ce_r <= 1'b0;
      if (is_clearing(state)) begin
        presc <= '0;
      end else if (is_running(state)) begin
        if (presc != PRE_MAX) begin
          presc <= presc + 1'b1;
        end else if (is_running(state_nxt)) begin
          presc    <= '0;
          cnt_ce_r <= 1'b1;
        end
      end

      if (state == ST_RUN && state_nxt == ST_LAP_RUN) lap_reg <= sw.cnt_in;
    end
  end

  assign sw.cnt_ce     = cnt_ce_r;
  assign sw.cnt_clr    = cnt_clr_r;
  assign sw.run_led    = run_led_r;
  assign sw.lap_active = lap_active_r;
  assign sw.disp_out   = lap_active_r ? lap_reg : sw.cnt_in;

endmodule
